// File: rtl/param_counter.sv
// rtl/param_counter.sv - WIDTH-bit up/down counter with wrap/saturate/one-shot end-of-range modes
// Optional step prescaler compiled in with PARAM_COUNTER_PRESCALE_EN.
module param_counter #(
    parameter int WIDTH      = 4,
    parameter int MAX_VAL    = 2**WIDTH-1,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  ovf_clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      counter_out,
    output logic                  overflow_out,
    output logic                  overflow_sticky,
    output logic                  running
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    typedef enum logic {COUNT, HALT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count_next;
    logic             ovf_next;
    logic             sticky_next;
    logic             tick;
    logic             step;
    logic             at_end;

`ifdef PARAM_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = (pre_cnt >= prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = 1'b1;
`endif

    assign step   = enable & tick;
    assign at_end = up_down ? (counter_out == MAX_CNT) : (counter_out == '0);

    always_comb begin
        state_next  = state;
        count_next  = counter_out;
        ovf_next    = 1'b0;
        sticky_next = overflow_sticky & ~ovf_clear;
        if (load) begin
            count_next = (load_value > MAX_CNT) ? MAX_CNT : load_value;
            state_next = COUNT;
        end else if (state == COUNT && step) begin
            if (at_end) begin
                // Boundary event: a set of the sticky flag beats a same-cycle clear.
                ovf_next    = 1'b1;
                sticky_next = 1'b1;
                case (mode)
                    2'b01:   count_next = counter_out;
                    2'b10:   state_next = HALT;
                    default: count_next = up_down ? '0 : MAX_CNT;
                endcase
            end else begin
                count_next = up_down ? counter_out + WIDTH'(1) : counter_out - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= COUNT;
            counter_out     <= '0;
            overflow_out    <= 1'b0;
            overflow_sticky <= 1'b0;
            running         <= 1'b1;
        end else begin
            state           <= state_next;
            counter_out     <= count_next;
            overflow_out    <= ovf_next;
            overflow_sticky <= sticky_next;
            running         <= (state_next == COUNT);
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - scoreboard bench for param_counter (MAX_VAL=15 and MAX_VAL=9 instances)
module tb_param_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       up_down;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_value;
    logic       ovf_clear;
    logic [3:0] prescale;

    logic [3:0] cnt_a, cnt_b;
    logic       ovf_a, ovf_b, stk_a, stk_b, run_a, run_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit use_b;
        int cnt;
        bit ovf;
        bit stk;
        bit run;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .PRESCALE_W(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
        .load(load), .load_value(load_value), .ovf_clear(ovf_clear), .prescale(prescale),
        .counter_out(cnt_a), .overflow_out(ovf_a), .overflow_sticky(stk_a), .running(run_a)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE_W(4)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
        .load(load), .load_value(load_value), .ovf_clear(ovf_clear), .prescale(prescale),
        .counter_out(cnt_b), .overflow_out(ovf_b), .overflow_sticky(stk_b), .running(run_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_c(input bit use_b, input int cnt, input bit ovf, input bit stk, input bit run);
        exp_t e;
        e.use_b = use_b;
        e.cnt   = cnt;
        e.ovf   = ovf;
        e.stk   = stk;
        e.run   = run;
        sb.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (e.use_b) begin
                check("b_count", int'(cnt_b), e.cnt);
                check("b_overflow", int'(ovf_b), int'(e.ovf));
                check("b_sticky", int'(stk_b), int'(e.stk));
                check("b_running", int'(run_b), int'(e.run));
            end else begin
                check("a_count", int'(cnt_a), e.cnt);
                check("a_overflow", int'(ovf_a), int'(e.ovf));
                check("a_sticky", int'(stk_a), int'(e.stk));
                check("a_running", int'(run_a), int'(e.run));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_count"}, int'(cnt_a), 0);
        check({tag, "_a_overflow"}, int'(ovf_a), 0);
        check({tag, "_a_sticky"}, int'(stk_a), 0);
        check({tag, "_a_running"}, int'(run_a), 1);
        check({tag, "_b_count"}, int'(cnt_b), 0);
        check({tag, "_b_overflow"}, int'(ovf_b), 0);
        check({tag, "_b_sticky"}, int'(stk_b), 0);
        check({tag, "_b_running"}, int'(run_b), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pre_en[8]  = '{1, 1, 1, 1, 0, 0, 1, 1};
`ifdef PARAM_COUNTER_PRESCALE_EN
        int pre_exp[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
`else
        int pre_exp[8] = '{1, 2, 3, 4, 4, 4, 5, 6};
`endif
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; mode = 2'b00; load = 1'b0;
        load_value = '0; ovf_clear = 1'b0; prescale = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        // Wrap up on the full-range instance: 1..15, 0 (pulse), 1..4
        enable = 1'b1; up_down = 1'b1; mode = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            expect_c(0, i % 16, i == 16, i >= 16, 1);
            cycle();
        end

        // Saturate down after loading 3
        load = 1'b1; load_value = 4'd3; enable = 1'b0;
        expect_c(0, 3, 0, 1, 1);
        cycle();
        load = 1'b0; mode = 2'b01; up_down = 1'b0; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_c(0, (i < 3) ? 2 - i : 0, i >= 3, 1, 1);
            cycle();
        end
        ovf_clear = 1'b1;
        expect_c(0, 0, 1, 1, 1);
        cycle();
        enable = 1'b0;
        expect_c(0, 0, 0, 0, 1);
        cycle();
        ovf_clear = 1'b0;

        // One-shot on MAX_VAL=9; a mode change must not release HALT
        do_reset();
        check_reset_state("reset2");
        mode = 2'b10; up_down = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            expect_c(1, i, 0, 0, 1);
            cycle();
        end
        expect_c(1, 9, 1, 1, 0);
        cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode = 2'b00;
            expect_c(1, 9, 0, 1, 0);
            cycle();
        end
        load = 1'b1; load_value = 4'd5;
        expect_c(1, 5, 0, 1, 1);
        cycle();
        load = 1'b0; mode = 2'b10;
        expect_c(1, 6, 0, 1, 1);
        cycle();
        expect_c(1, 7, 0, 1, 1);
        cycle();

        // Load beats a would-be wrap, and clamps to MAX_VAL
        mode = 2'b00;
        expect_c(1, 8, 0, 1, 1);
        cycle();
        expect_c(1, 9, 0, 1, 1);
        cycle();
        load = 1'b1; load_value = 4'd4;
        expect_c(1, 4, 0, 1, 1);
        cycle();
        load_value = 4'd15;
        expect_c(1, 9, 0, 1, 1);
        cycle();
        load = 1'b0;
        expect_c(1, 0, 1, 1, 1);
        cycle();

        // Async reset mid-cycle at count 7
        for (int i = 1; i <= 7; i++) begin
            expect_c(1, i, 0, 1, 1);
            cycle();
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Prescaler: prescale=2 with an enable gap
        prescale = 4'd2; mode = 2'b00; up_down = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enable = pre_en[i][0];
            expect_c(0, pre_exp[i], 0, 0, 1);
            cycle();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
